// File: rtl/tenyr_pkg.sv
// Shared types and constants for the tenyr RAM operand-port arbiter.
package tenyr_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } arb_state_e;

    localparam int unsigned DefaultAw = 32;
    localparam int unsigned DefaultDw = 32;

    localparam logic [31:0] RESET_VECTOR = 32'h0000_1000;

endpackage

// File: rtl/rr_picker.sv
// Combinational rotating priority encoder over the request vector.
// Defining TENYR_ARB_FIXED_PRIO_EN selects fixed lowest-index-wins priority instead.
module rr_picker
    import tenyr_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   last_i,
    output logic [IW-1:0]   grant_o,
    output logic            any_req_o
);

    assign any_req_o = |req_i;

`ifdef TENYR_ARB_FIXED_PRIO_EN
    // last is still tracked by the caller but plays no part in the choice.
    logic unused_last;
    assign unused_last = ^last_i;

    always_comb begin
        grant_o = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (req_i[i]) grant_o = IW'(i);
        end
    end
`else
    localparam logic [IW:0] NreqW = (IW + 1)'(NREQ);

    logic [IW:0]   sum;
    logic [IW-1:0] cand;
    logic          found;

    // Search starts one past the previous winner and wraps modulo NREQ.
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        sum     = '0;
        cand    = '0;
        for (int k = 1; k <= int'(NREQ); k++) begin
            sum = {1'b0, last_i} + (IW + 1)'(k);
            if (sum >= NreqW) sum = sum - NreqW;
            cand = sum[IW-1:0];
            if (!found && req_i[cand]) begin
                grant_o = cand;
                found   = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing RAM port 0 between NREQ masters with a fixed-latency access.
// Build option: TENYR_ARB_FIXED_PRIO_EN switches the picker to fixed priority.
module mem_port_arbiter
    import tenyr_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned WAIT = 1,
    parameter int unsigned AW   = DefaultAw,
    parameter int unsigned DW   = DefaultDw
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [NREQ-1:0]    req_i,
    input  logic [NREQ-1:0]    rw_i,
    input  logic [NREQ*AW-1:0] addr_i,
    input  logic [NREQ*DW-1:0] wdata_i,
    output logic [NREQ-1:0]    ack_o,
    output logic [DW-1:0]      rdata_o,
    output logic               mem_en_o,
    output logic               mem_we_o,
    output logic [AW-1:0]      mem_addr_o,
    output logic [DW-1:0]      mem_wdata_o,
    input  logic [DW-1:0]      mem_rdata_i
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned CW = (WAIT > 1) ? $clog2(WAIT) : 1;
    localparam logic [CW-1:0] CntLoad = CW'(WAIT - 1);
    localparam logic [IW-1:0] LastRst = IW'(NREQ - 1);

    arb_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   last_q, last_d;
    logic [IW-1:0]   win_q, win_d;
    logic            rw_q, rw_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            mem_en_q, mem_en_d;

    logic [IW-1:0]   grant;
    logic            any_req;
    logic [AW-1:0]   addr_arr  [NREQ];
    logic [DW-1:0]   wdata_arr [NREQ];

    for (genvar i = 0; i < int'(NREQ); i++) begin : g_unpack
        assign addr_arr[i]  = addr_i[i*AW +: AW];
        assign wdata_arr[i] = wdata_i[i*DW +: DW];
    end

    rr_picker #(
        .NREQ(NREQ),
        .IW  (IW)
    ) u_picker (
        .req_i    (req_i),
        .last_i   (last_q),
        .grant_o  (grant),
        .any_req_o(any_req)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        win_d    = win_q;
        rw_d     = rw_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        ack_d    = '0;
        mem_en_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    win_d    = grant;
                    last_d   = grant;
                    rw_d     = rw_i[grant];
                    addr_d   = addr_arr[grant];
                    wdata_d  = wdata_arr[grant];
                    cnt_d    = CntLoad;
                    mem_en_d = 1'b1;
                    state_d  = StAccess;
                end
            end
            StAccess: begin
                if (cnt_q == '0) begin
                    if (!rw_q) rdata_d = mem_rdata_i;
                    ack_d[win_q] = 1'b1;
                    state_d      = StResp;
                end else begin
                    cnt_d    = cnt_q - 1'b1;
                    mem_en_d = 1'b1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            last_q   <= LastRst;
            win_q    <= '0;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            ack_q    <= '0;
            mem_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            win_q    <= win_d;
            rw_q     <= rw_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            ack_q    <= ack_d;
            mem_en_q <= mem_en_d;
        end
    end

    // Single strobe on the last access cycle, decoded from registered state only.
    assign mem_we_o    = rw_q & (state_q == StAccess) & (cnt_q == '0);
    assign mem_en_o    = mem_en_q;
    assign ack_o       = ack_q;
    assign rdata_o     = rdata_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

endmodule
